// File: rtl/ml_pkg.sv
// Shared definitions for the ml_* host-link receiver: byte width, beat count
// per byte, receiver state encoding and a constant clog2 helper.
package ml_pkg;

  localparam int ML_BYTE_W = 8;

  typedef enum logic {
    ML_RX_IDLE  = 1'b0,
    ML_RX_SHIFT = 1'b1
  } ml_rx_state_t;

  // Sampling edges needed to assemble one byte.
  function automatic int ml_beats(input int lanes);
    return ML_BYTE_W / lanes;
  endfunction

  function automatic int ml_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ml_sync_fifo.sv
// Single-clock FIFO for the receiver's {first, data} words. Keeps pointers,
// occupancy, full/empty and flags a push that had to be dropped.
module ml_sync_fifo
  import ml_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic [ml_clog2(DEPTH):0]  level,
  output logic                      empty,
  output logic                      ovf
);

  localparam int AW = ml_clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & full & ~pop_ok;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Storage array; contents are only meaningful below the occupancy.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ml_qspi_rx.sv
// Host-link receiver for the ml_* QSPI-style port. Synchronises ml_csb and
// ml_clk, detects sampling edges (SDR or DDR), shifts LANES bits per edge
// MSB-first into bytes tagged with a frame-start flag and queues them.
// Optional host flow control on ml_rdy is built when ML_QSPI_RX_RDY_EN is defined.
module ml_qspi_rx
  import ml_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int RDY_MARGIN  = 1
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           ml_csb,
  input  logic                           ml_clk,
  input  logic [LANES-1:0]               ml_di,
  input  logic                           cfg_ddr,
  output logic [7:0]                     out_data,
  output logic                           out_first,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ml_clog2(FIFO_DEPTH):0]  level,
  input  logic                           clr_err,
  output logic                           ml_err,
  output logic                           ml_rdy
);

  localparam int         LW        = ml_clog2(FIFO_DEPTH) + 1;
  localparam int         SHW       = ML_BYTE_W - LANES;
  localparam logic [2:0] LAST_BEAT = 3'(ml_beats(LANES) - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_chk_lanes
    $error("ml_qspi_rx: LANES must be 1, 2 or 4");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("ml_qspi_rx: SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("ml_qspi_rx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (RDY_MARGIN < 0 || RDY_MARGIN >= FIFO_DEPTH) begin : g_chk_margin
    $error("ml_qspi_rx: RDY_MARGIN must lie in 0..FIFO_DEPTH-1");
  end

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   csb_prev;
  logic                   clk_prev;
  logic [LANES-1:0]       di_neg;
  logic [LANES-1:0]       di_dly [SYNC_STAGES+1];

  logic                   sync_csb;
  logic                   sync_clk;
  logic                   rise;
  logic                   fall;
  logic                   csb_fall;
  logic                   sample;
  logic [LANES-1:0]       lane_data;

  ml_rx_state_t           state;
  logic [2:0]             beat;
  logic                   first;
  logic                   ddr_q;
  logic                   shift_en;
  logic                   frame_hit;
  logic [SHW-1:0]         sh;
  logic [ML_BYTE_W-1:0]   assembled;
  logic                   push_p;
  logic [ML_BYTE_W:0]     push_word_p;

  logic [ML_BYTE_W:0]     head;
  logic                   fifo_empty;
  logic                   ovf_hit;
  logic                   overflow;
  logic                   frame_err;
  logic                   overflow_n;
  logic                   frame_err_n;

  // ---- capture stage: pad data on the falling system edge ----
  // Half-cycle capture keeps the pad sample away from the posedge sync flops.
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) di_neg <= '0;
    else         di_neg <= ml_di;
  end

  // ---- synchroniser stages: csb/clk sync and matching data delay ----
  // Data lags one flop more than sync_clk so it lines up with the detected edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= '0;
      clk_sync <= '0;
      csb_prev <= 1'b0;
      clk_prev <= 1'b0;
      for (int i = 0; i <= SYNC_STAGES; i++) di_dly[i] <= '0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], ml_csb};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ml_clk};
      csb_prev  <= csb_sync[SYNC_STAGES-1];
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      di_dly[0] <= di_neg;
      for (int i = 1; i <= SYNC_STAGES; i++) di_dly[i] <= di_dly[i-1];
    end
  end

  // ---- edge detect ----
  assign sync_csb  = csb_sync[SYNC_STAGES-1];
  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign rise      = sync_clk & ~clk_prev;
  assign fall      = ~sync_clk & clk_prev & ddr_q;
  assign csb_fall  = csb_prev & ~sync_csb;
  assign sample    = (rise | fall) & ~sync_csb;
  assign lane_data = di_dly[SYNC_STAGES];

  assign shift_en  = (state == ML_RX_SHIFT) & sample;
  assign frame_hit = (state == ML_RX_SHIFT) & sync_csb & (beat != 3'd0);
  assign assembled = {sh, lane_data};

  // Frame/beat control; a frame only opens on a fresh csb falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= ML_RX_IDLE;
      beat   <= 3'd0;
      first  <= 1'b0;
      ddr_q  <= 1'b0;
      push_p <= 1'b0;
    end else begin
      push_p <= 1'b0;
      case (state)
        ML_RX_IDLE: begin
          ddr_q <= cfg_ddr;
          if (csb_fall) begin
            state <= ML_RX_SHIFT;
            beat  <= 3'd0;
            first <= 1'b1;
          end
        end
        ML_RX_SHIFT: begin
          if (sync_csb) begin
            state <= ML_RX_IDLE;
            beat  <= 3'd0;
          end else if (sample) begin
            if (beat == LAST_BEAT) begin
              push_p <= 1'b1;
              beat   <= 3'd0;
              first  <= 1'b0;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        default: state <= ML_RX_IDLE;
      endcase
    end
  end

  // ---- shift stage: byte assembly, push word registered for the FIFO ----
  // Shift register and push word; only read under push_p, so never reset.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      sh          <= assembled[SHW-1:0];
      push_word_p <= {first, assembled};
    end
  end

  // ---- queue stage ----
  ml_sync_fifo #(
    .WIDTH (ML_BYTE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_p),
    .push_data (push_word_p),
    .pop       (out_ready),
    .head      (head),
    .level     (level),
    .empty     (fifo_empty),
    .ovf       (ovf_hit)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? head[ML_BYTE_W-1:0] : '0;
  assign out_first = out_valid & head[ML_BYTE_W];

  // A new error in the same cycle as clr_err wins over the clear.
  assign overflow_n  = ovf_hit   | (overflow  & ~clr_err);
  assign frame_err_n = frame_hit | (frame_err & ~clr_err);

  // Sticky error flags and their registered summary.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      ml_err    <= 1'b0;
    end else begin
      overflow  <= overflow_n;
      frame_err <= frame_err_n;
      ml_err    <= overflow_n | frame_err_n;
    end
  end

`ifdef ML_QSPI_RX_RDY_EN
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(RDY_MARGIN);

  // Host flow control: ready while enough entries are free and csb is active.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ml_rdy <= 1'b0;
    else         ml_rdy <= ((DEPTH_L - level) > MARGIN_L) & ~sync_csb;
  end
`else
  assign ml_rdy = 1'b0;
`endif

endmodule
